// File: rtl/mem_scheduler_pkg.sv
// Shared types and helpers for the byte-serial memory scheduler.
package mem_scheduler_pkg;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
   typedef enum logic [1:0] {REQ_IF, REQ_LD, REQ_ST} req_id_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic is_io(input logic [31:0] addr);
      return addr[17:16] == 2'b11;
   endfunction

   function automatic logic [2:0] byte_count(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [2:0] funct3);
      case (funct3)
         F3_B:    return {{24{raw[7]}}, raw[7:0]};
         F3_H:    return {{16{raw[15]}}, raw[15:0]};
         F3_BU:   return {24'h0, raw[7:0]};
         F3_HU:   return {16'h0, raw[15:0]};
         default: return raw;
      endcase
   endfunction

endpackage

// File: rtl/mem_scheduler_arbiter.sv
// Fixed priority (store > load > ifetch) with a starvation counter that
// lets a waiting ifetch win once it has lost STARVE_LIMIT arbitrations.
module mem_rr_arbiter
   import mem_scheduler_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 3
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    en,
   input  logic    if_req,
   input  logic    ld_req,
   input  logic    st_req,
   output logic    grant,
   output req_id_t grant_id
);

   logic [CNT_W-1:0] starve_cnt;
   logic             if_boost;

   always_comb begin
      if_boost = if_req && (starve_cnt >= CNT_W'(STARVE_LIMIT));
      grant    = en && (if_req || ld_req || st_req);
      if (if_boost)    grant_id = REQ_IF;
      else if (st_req) grant_id = REQ_ST;
      else if (ld_req) grant_id = REQ_LD;
      else             grant_id = REQ_IF;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (grant) begin
         if (grant_id == REQ_IF)
            starve_cnt <= '0;
         else if (if_req && starve_cnt != '1)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_scheduler.sv
// Arbitrates ifetch/load/store onto the byte-wide memory bus and runs each
// grant as a little-endian byte-serial read or write transaction.
module mem_scheduler
   import mem_scheduler_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 3
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        clear_all,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        ld_req,
   input  logic [31:0] ld_addr,
   input  logic [2:0]  ld_funct3,
   output logic        ld_done,
   output logic [31:0] ld_data,
   input  logic        st_req,
   input  logic [31:0] st_addr,
   input  logic [2:0]  st_funct3,
   input  logic [31:0] st_data,
   output logic        st_done
);

   state_t      state;
   req_id_t     owner;
   logic [31:0] wdata;
   logic [31:0] rbuf;
   logic [31:0] rbuf_next;
   logic [31:0] addr_sel;
   logic [2:0]  nbytes;
   logic [2:0]  funct3;
   logic [2:0]  idx;
   logic        io_st;
   logic        if_done_q;
   logic        ld_done_q;
   logic        st_done_q;
   logic        grant;
   req_id_t     grant_id;

   mem_rr_arbiter #(
      .STARVE_LIMIT(STARVE_LIMIT),
      .CNT_W       (CNT_W)
   ) u_arb (
      .clk     (clk_in),
      .rst     (rst_in),
      .en      (rdy_in && state == IDLE && !clear_all),
      .if_req  (if_req),
      .ld_req  (ld_req),
      .st_req  (st_req),
      .grant   (grant),
      .grant_id(grant_id)
   );

   always_comb begin
      case (grant_id)
         REQ_ST:  addr_sel = st_addr;
         REQ_LD:  addr_sel = ld_addr;
         default: addr_sel = if_addr;
      endcase
   end

   // Byte idx-1 arrives on mem_din one cycle after its address was driven.
   always_comb begin
      rbuf_next = rbuf;
      case (idx)
         3'd1:    rbuf_next[7:0]   = mem_din;
         3'd2:    rbuf_next[15:8]  = mem_din;
         3'd3:    rbuf_next[23:16] = mem_din;
         3'd4:    rbuf_next[31:24] = mem_din;
         default: ;
      endcase
   end

   // Stall and flush gating is combinational so the registered pulses stay single-cycle.
   always_comb begin
      mem_wr  = rdy_in && state == WRITE && !(io_st && io_buffer_full);
      if_done = if_done_q && rdy_in && !clear_all;
      ld_done = ld_done_q && rdy_in && !clear_all;
      st_done = st_done_q && rdy_in;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state     <= IDLE;
         owner     <= REQ_IF;
         wdata     <= '0;
         rbuf      <= '0;
         nbytes    <= '0;
         funct3    <= '0;
         idx       <= '0;
         io_st     <= 1'b0;
         mem_a     <= '0;
         mem_dout  <= '0;
         if_data   <= '0;
         ld_data   <= '0;
         if_done_q <= 1'b0;
         ld_done_q <= 1'b0;
         st_done_q <= 1'b0;
      end else if (rdy_in) begin
         if_done_q <= 1'b0;
         ld_done_q <= 1'b0;
         st_done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  owner <= grant_id;
                  idx   <= '0;
                  rbuf  <= '0;
                  mem_a <= addr_sel;
                  case (grant_id)
                     REQ_ST: begin
                        nbytes   <= byte_count(st_funct3);
                        wdata    <= st_data;
                        io_st    <= is_io(st_addr);
                        mem_dout <= st_data[7:0];
                        state    <= WRITE;
                     end
                     REQ_LD: begin
                        nbytes <= byte_count(ld_funct3);
                        funct3 <= ld_funct3;
                        state  <= READ;
                     end
                     default: begin
                        nbytes <= 3'd4;
                        funct3 <= F3_W;
                        state  <= READ;
                     end
                  endcase
               end
            end
            READ: begin
               if (clear_all) begin
                  state <= IDLE;
                  mem_a <= '0;
               end else begin
                  rbuf <= rbuf_next;
                  if (idx == nbytes) begin
                     state <= DONE;
                     if (owner == REQ_IF) begin
                        if_data   <= rbuf_next;
                        if_done_q <= 1'b1;
                     end else begin
                        ld_data   <= extend_load(rbuf_next, funct3);
                        ld_done_q <= 1'b1;
                     end
                  end else begin
                     idx <= idx + 3'd1;
                     if (idx + 3'd1 < nbytes)
                        mem_a <= mem_a + 32'd1;
                  end
               end
            end
            WRITE: begin
               if (!(io_st && io_buffer_full)) begin
                  if (idx == nbytes - 3'd1) begin
                     state     <= DONE;
                     st_done_q <= 1'b1;
                  end else begin
                     idx      <= idx + 3'd1;
                     mem_a    <= mem_a + 32'd1;
                     mem_dout <= wdata[15:8];
                     wdata    <= {8'h00, wdata[31:8]};
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               if (clear_all && owner != REQ_ST)
                  mem_a <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_scheduler.sv
// Scoreboard bench for mem_scheduler: directed scenarios plus randomized
// single transactions checked against a byte-array memory model.
module tb_mem_scheduler;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        clear_all;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;
   logic        if_req, ld_req, st_req;
   logic [31:0] if_addr, ld_addr, st_addr, st_data;
   logic [2:0]  ld_funct3, st_funct3;
   logic        if_done, ld_done, st_done;
   logic [31:0] if_data, ld_data;

   logic rdy_force, io_force;
   logic rand_en = 1'b0;
   logic rdy_rand, io_rand;
   assign rdy_in         = rdy_force & rdy_rand;
   assign io_buffer_full = io_force | io_rand;

   always #5 clk_in = ~clk_in;

   mem_scheduler #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_all(clear_all),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_funct3(ld_funct3), .ld_done(ld_done), .ld_data(ld_data),
      .st_req(st_req), .st_addr(st_addr), .st_funct3(st_funct3), .st_data(st_data), .st_done(st_done)
   );

   int checks = 0;
   int failures = 0;

   function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endfunction

   // Power-on memory contents, with the directed test bytes planted.
   function automatic logic [7:0] init_byte(input logic [31:0] a);
      case (a)
         32'h100: return 8'h11;
         32'h101: return 8'h22;
         32'h102: return 8'h33;
         32'h103: return 8'h44;
         32'h200: return 8'h80;
         32'h300: return 8'h34;
         32'h301: return 8'hF2;
         default: return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
      endcase
   endfunction

   // Physical memory: 256 KiB, data returned one cycle after the address.
   logic [7:0] phys    [0:(1<<18)-1];
   logic       written [0:(1<<18)-1];
   always @(posedge clk_in) begin
      if (rst_in) begin
         mem_din <= 8'h00;
      end else if (rdy_in) begin
         mem_din <= written[mem_a[17:0]] ? phys[mem_a[17:0]] : init_byte({14'h0, mem_a[17:0]});
         if (mem_wr) begin
            phys[mem_a[17:0]]    <= mem_dout;
            written[mem_a[17:0]] <= 1'b1;
         end
      end
   end

   always @(posedge clk_in) begin
      #1;
      if (rand_en) begin
         rdy_rand = ($urandom_range(0, 7) != 0);
         io_rand  = ($urandom_range(0, 2) == 0);
      end else begin
         rdy_rand = 1'b1;
         io_rand  = 1'b0;
      end
   end

   // Reference model state and scoreboard queues.
   logic [7:0]  ref_mem [int];
   logic [31:0] exp_if_q [$];
   logic [31:0] exp_ld_q [$];
   logic [39:0] exp_wr_q [$];
   int          st_pending = 0;

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      int key = int'(a[17:0]);
      return ref_mem.exists(key) ? ref_mem[key] : init_byte({14'h0, a[17:0]});
   endfunction

   function automatic int size_of(input logic [2:0] f3);
      logic [1:0] sz = f3[1:0];
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
      logic [31:0] w = 0;
      int v;
      for (int i = 0; i < size_of(f3); i++)
         w = w + (32'(ref_rd(addr + 32'(i))) << (8 * i));
      case (f3)
         3'b000: begin v = int'(w[7:0]);  if (v >= 128)   v -= 256;   w = v; end
         3'b001: begin v = int'(w[15:0]); if (v >= 32768) v -= 65536; w = v; end
         default: ;
      endcase
      return w;
   endfunction

   task automatic start_req(input int kind, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] data);
      case (kind)
         0: begin
            if_req = 1'b1; if_addr = addr;
            exp_if_q.push_back(model_load(addr, 3'b010));
         end
         1: begin
            ld_req = 1'b1; ld_addr = addr; ld_funct3 = f3;
            exp_ld_q.push_back(model_load(addr, f3));
         end
         default: begin
            st_req = 1'b1; st_addr = addr; st_funct3 = f3; st_data = data;
            for (int i = 0; i < size_of(f3); i++) begin
               logic [7:0] b = 8'(data >> (8 * i));
               exp_wr_q.push_back({addr + 32'(i), b});
               ref_mem[int'(18'(addr + 32'(i)))] = b;
            end
            st_pending++;
         end
      endcase
   endtask

   task automatic drop_req(input int kind);
      case (kind)
         0:       if_req = 1'b0;
         1:       ld_req = 1'b0;
         default: st_req = 1'b0;
      endcase
   endtask

   // lat = number of clock edges from the current cycle to the done cycle.
   task automatic wait_done(output int kind, output int lat);
      kind = -1;
      lat  = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_in);
         lat = i;
         if (if_done) begin kind = 0; return; end
         if (ld_done) begin kind = 1; return; end
         if (st_done) begin kind = 2; return; end
      end
      checks++;
      failures++;
      $display("FAIL done_timeout got=none exp=done_pulse t=%0t", $time);
   endtask

   task automatic run_one(input int kind, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] data, input int exp_lat, input string tag);
      int k, lat;
      @(posedge clk_in); #1;
      start_req(kind, addr, f3, data);
      wait_done(k, lat);
      drop_req(kind);
      check({tag, "_kind"}, k, kind);
      if (exp_lat >= 0) check({tag, "_lat"}, lat, exp_lat);
   endtask

   // Monitor: every done pulse and every written byte pops the scoreboard.
   always @(negedge clk_in) begin
      if (!rst_in) begin
         if (if_done) begin
            check("if_pending", exp_if_q.size() > 0, 1);
            if (exp_if_q.size() > 0) check("if_data", if_data, exp_if_q.pop_front());
         end
         if (ld_done) begin
            check("ld_pending", exp_ld_q.size() > 0, 1);
            if (exp_ld_q.size() > 0) check("ld_data", ld_data, exp_ld_q.pop_front());
         end
         if (mem_wr) begin
            logic [39:0] e;
            check("wr_io_gate", mem_a[17:16] == 2'b11 && io_buffer_full, 0);
            check("wr_pending", exp_wr_q.size() > 0, 1);
            if (exp_wr_q.size() > 0) begin
               e = exp_wr_q.pop_front();
               check("wr_addr", mem_a, e[39:8]);
               check("wr_data", {24'h0, mem_dout}, {24'h0, e[7:0]});
            end
         end
         if (st_done) begin
            check("st_pending", st_pending > 0, 1);
            check("st_bytes_left", exp_wr_q.size(), 0);
            if (st_pending > 0) st_pending--;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=running exp=finished t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int k, lat;
      logic [31:0] a;
      logic [2:0]  f3;
      logic [2:0]  ld_f3s [5];
      ld_f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

      rst_in = 1'b1; rdy_force = 1'b1; io_force = 1'b0; clear_all = 1'b0;
      if_req = 0; ld_req = 0; st_req = 0;
      if_addr = 0; ld_addr = 0; st_addr = 0; st_data = 0; ld_funct3 = 0; st_funct3 = 0;
      for (int i = 0; i < (1 << 18); i++) written[i] = 1'b0;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check("rst_mem_a", mem_a, 0);
      check("rst_mem_dout", {24'h0, mem_dout}, 0);
      check("rst_mem_wr", mem_wr, 0);
      check("rst_dones", {if_done, ld_done, st_done}, 0);
      check("rst_if_data", if_data, 0);
      check("rst_ld_data", ld_data, 0);
      rst_in = 1'b0;

      // LW 0x100 with address sequence and latency N+2.
      @(posedge clk_in); #1;
      start_req(1, 32'h100, 3'b010, 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk_in); #1;
         check("lw_addr_seq", mem_a, 32'h100 + 32'(i));
      end
      wait_done(k, lat);
      drop_req(1);
      check("lw_kind", k, 1);
      check("lw_lat", 4 + lat, 6);
      check("lw_const", ld_data, 32'h44332211);

      run_one(1, 32'h200, 3'b000, 0, 3, "lb");
      check("lb_const", ld_data, 32'hFFFFFF80);
      run_one(1, 32'h200, 3'b100, 0, 3, "lbu");
      check("lbu_const", ld_data, 32'h00000080);
      run_one(1, 32'h300, 3'b001, 0, 4, "lh");
      check("lh_const", ld_data, 32'hFFFFF234);

      // I/O store throttled by 3 buffer-full cycles after the first byte.
      @(posedge clk_in); #1;
      start_req(2, 32'h30000, 3'b010, 32'hDEADBEEF);
      @(posedge clk_in); #1;
      @(posedge clk_in); #1;
      io_force = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_in);
         check("io_full_no_wr", mem_wr, 0);
         @(posedge clk_in); #1;
      end
      io_force = 1'b0;
      wait_done(k, lat);
      drop_req(2);
      check("io_st_kind", k, 2);
      check("io_st_lat", 5 + lat, 8);

      // Starvation: ifetch waits while store and load alternate.
      @(posedge clk_in); #1;
      start_req(0, 32'h1000, 3'b010, 0);
      start_req(2, 32'h2000, 3'b010, $urandom);
      for (int j = 0; j < 4; j++) begin
         wait_done(k, lat);
         check("starve_winner", k, (j % 2 == 0) ? 2 : 1);
         drop_req(k < 0 ? 2 : k);
         if (j % 2 == 0) start_req(1, 32'h2100 + 32'(j), 3'b010, 0);
         else            start_req(2, 32'h2200 + 32'(j * 4), 3'b010, $urandom);
      end
      wait_done(k, lat);
      check("starve_if_wins", k, 0);
      drop_req(0);
      start_req(0, 32'h1004, 3'b010, 0);
      wait_done(k, lat);
      check("starve_cnt_cleared", k, 2);
      drop_req(2);
      wait_done(k, lat);
      check("starve_if_last", k, 0);
      drop_req(0);

      // clear_all while ifetch reads byte 2: abort, mem_a=0, IDLE next cycle.
      @(posedge clk_in); #1;
      if_req = 1'b1; if_addr = 32'h400;
      repeat (3) begin @(posedge clk_in); #1; end
      check("clr_if_byte2", mem_a, 32'h402);
      clear_all = 1'b1; if_req = 1'b0;
      @(posedge clk_in); #1;
      clear_all = 1'b0;
      check("clr_if_mem_a", mem_a, 0);
      start_req(1, 32'h500, 3'b010, 0);
      wait_done(k, lat);
      drop_req(1);
      check("clr_if_idle_kind", k, 1);
      check("clr_if_idle_lat", lat, 6);

      // clear_all during SH write is ignored.
      @(posedge clk_in); #1;
      start_req(2, 32'h1234, 3'b001, 32'h0000A55A);
      @(posedge clk_in); #1;
      clear_all = 1'b1;
      @(posedge clk_in); #1;
      clear_all = 1'b0;
      wait_done(k, lat);
      drop_req(2);
      check("clr_sh_kind", k, 2);
      check("clr_sh_lat", 2 + lat, 3);

      // clear_all in IDLE blocks that cycle's grant.
      @(posedge clk_in); #1;
      clear_all = 1'b1;
      start_req(1, 32'h600, 3'b010, 0);
      @(posedge clk_in); #1;
      clear_all = 1'b0;
      wait_done(k, lat);
      drop_req(1);
      check("clr_idle_lat", 1 + lat, 7);

      // rdy_in low for 5 cycles mid-LW.
      @(posedge clk_in); #1;
      start_req(1, 32'h700, 3'b010, 0);
      @(posedge clk_in); #1;
      @(posedge clk_in); #1;
      check("stall_addr", mem_a, 32'h701);
      rdy_force = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_in); #1;
         check("stall_frozen", {mem_a[30:0], mem_wr | ld_done}, {31'h701, 1'b0});
      end
      rdy_force = 1'b1;
      wait_done(k, lat);
      drop_req(1);
      check("stall_kind", k, 1);
      check("stall_lat", 7 + lat, 11);

      // Randomized single transactions with random stalls and I/O back-pressure.
      rand_en = 1'b1;
      for (int n = 0; n < 150; n++) begin
         int kind = $urandom_range(0, 2);
         a = 32'($urandom_range(0, (1 << 18) - 16));
         if (kind == 0) begin
            run_one(0, a & ~32'h3, 3'b010, 0, -1, "rnd_if");
         end else if (kind == 1) begin
            f3 = ld_f3s[$urandom_range(0, 4)];
            run_one(1, a, f3, 0, -1, "rnd_ld");
         end else begin
            if ($urandom_range(0, 3) == 0) a = {14'h0, 2'b11, 16'($urandom_range(0, 16'hFFF0))};
            f3 = 3'($urandom_range(0, 2));
            run_one(2, a, f3, $urandom, -1, "rnd_st");
         end
      end
      rand_en = 1'b0;

      repeat (10) @(posedge clk_in);
      @(negedge clk_in);
      check("end_if_q", exp_if_q.size(), 0);
      check("end_ld_q", exp_ld_q.size(), 0);
      check("end_wr_q", exp_wr_q.size(), 0);
      check("end_st_pending", st_pending, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
